// File: rtl/seg_pkg.sv
// Shared constants and decode helpers for the 7-segment scan decoder.
// Segment patterns are active-low, bit6=g .. bit0=a.
package seg_pkg;

    localparam logic [3:0] SEG_BLANK_ANODE = 4'b1111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    typedef enum logic [1:0] {
        ANODE_BLANK,
        ANODE_DIGIT,
        ANODE_BAD
    } anode_class_e;

    typedef struct packed {
        anode_class_e cls;
        logic [1:0]   idx;
    } anode_info_t;

    // Returns {legal, nibble}; nibble is 0 when the pattern is not in the table.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG_HEX_0: res = 5'h10;
            SEG_HEX_1: res = 5'h11;
            SEG_HEX_2: res = 5'h12;
            SEG_HEX_3: res = 5'h13;
            SEG_HEX_4: res = 5'h14;
            SEG_HEX_5: res = 5'h15;
            SEG_HEX_6: res = 5'h16;
            SEG_HEX_7: res = 5'h17;
            SEG_HEX_8: res = 5'h18;
            SEG_HEX_9: res = 5'h19;
            SEG_HEX_A: res = 5'h1A;
            SEG_HEX_B: res = 5'h1B;
            SEG_HEX_C: res = 5'h1C;
            SEG_HEX_D: res = 5'h1D;
            SEG_HEX_E: res = 5'h1E;
            SEG_HEX_F: res = 5'h1F;
            default:   res = 5'h00;
        endcase
        return res;
    endfunction

    function automatic anode_info_t anode_classify(input logic [3:0] anode);
        anode_info_t info;
        info.cls = ANODE_BAD;
        info.idx = 2'd0;
        case (anode)
            SEG_BLANK_ANODE: info.cls = ANODE_BLANK;
            4'b1110: begin info.cls = ANODE_DIGIT; info.idx = 2'd0; end
            4'b1101: begin info.cls = ANODE_DIGIT; info.idx = 2'd1; end
            4'b1011: begin info.cls = ANODE_DIGIT; info.idx = 2'd2; end
            4'b0111: begin info.cls = ANODE_DIGIT; info.idx = 2'd3; end
            default: info.cls = ANODE_BAD;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/seg_dwell_detect.sv
// Dwell tracker: raises capture_stb once per stable {anode,seg} dwell after
// SETTLE_CYCLES consecutive unchanged cycles.
module seg_dwell_detect
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode_in,
    input  logic [6:0] seg_in,
    output logic       capture_stb,
    output logic [3:0] anode_stable,
    output logic [6:0] seg_stable
);

    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [10:0]      pair_q, pair_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [10:0]      pair_in;
    logic             changed;

    always_comb begin
        pair_in     = {anode_in, seg_in};
        changed     = (pair_in != pair_q);
        pair_d      = pair_in;
        cnt_d       = cnt_q;
        done_d      = done_q;
        capture_stb = 1'b0;
        if (changed) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else begin
            if (cnt_q != SETTLE_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((cnt_q == SETTLE_LAST) && !done_q) begin
                capture_stb = 1'b1;
                done_d      = 1'b1;
            end
        end
    end

    // Pair resets to all-1s so the idle state reads as a blank display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q <= '1;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            pair_q <= pair_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign anode_stable = pair_q[10:7];
    assign seg_stable   = pair_q[6:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side 7-segment scan decoder: rebuilds four hex digits from a multiplexed
// active-low seg/anode bus. Define SEG_SYNC_EN to add 2-flop input synchronizers.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  anode_in,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_pulse,
    output logic        err_pulse,
    output logic [1:0]  err_digit
);

    logic [3:0] anode_trk;
    logic [6:0] seg_trk;

`ifdef SEG_SYNC_EN
    logic [10:0] sync1_q, sync1_d;
    logic [10:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {anode_in, seg_in};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign anode_trk = sync2_q[10:7];
    assign seg_trk   = sync2_q[6:0];
`else
    assign anode_trk = anode_in;
    assign seg_trk   = seg_in;
`endif

    logic       capture_stb;
    logic [3:0] anode_stable;
    logic [6:0] seg_stable;

    seg_dwell_detect #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk         (clk),
        .rst         (rst),
        .anode_in    (anode_trk),
        .seg_in      (seg_trk),
        .capture_stb (capture_stb),
        .anode_stable(anode_stable),
        .seg_stable  (seg_stable)
    );

    logic [15:0] value_q, value_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  mask_q, mask_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;
    logic [1:0]  err_digit_q, err_digit_d;

    anode_info_t anode_info;
    logic [4:0]  seg_dec;
    logic [3:0]  mask_upd;

    always_comb begin
        value_d     = value_q;
        valid_d     = valid_q;
        mask_d      = mask_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        anode_info  = anode_classify(anode_stable);
        seg_dec     = seg_to_hex(seg_stable);
        mask_upd    = mask_q | (4'b0001 << anode_info.idx);

        if (capture_stb) begin
            case (anode_info.cls)
                ANODE_DIGIT: begin
                    if (seg_dec[4]) begin
                        value_d[{anode_info.idx, 2'b00} +: 4] = seg_dec[3:0];
                        valid_d[anode_info.idx]               = 1'b1;
                        // Frame completes on the same edge as the last nibble update.
                        if (mask_upd == 4'b1111) begin
                            frame_d = 1'b1;
                            mask_d  = '0;
                        end else begin
                            mask_d = mask_upd;
                        end
                    end else begin
                        valid_d[anode_info.idx] = 1'b0;
                        err_d                   = 1'b1;
                        err_digit_d             = anode_info.idx;
                    end
                end
                ANODE_BAD: begin
                    err_d       = 1'b1;
                    err_digit_d = 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q     <= '0;
            valid_q     <= '0;
            mask_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            value_q     <= value_d;
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign frame_pulse = frame_q;
    assign err_pulse   = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus a randomized
// scan, all compared cycle by cycle against a run-length reference model.
module tb_seg_scan_decoder;

    localparam int unsigned S = 4;
`ifdef SEG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  anode_in = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_pulse;
    logic        err_pulse;
    logic [1:0]  err_digit;

    seg_scan_decoder #(
        .SETTLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .anode_in   (anode_in),
        .value      (value),
        .digit_valid(digit_valid),
        .frame_pulse(frame_pulse),
        .err_pulse  (err_pulse),
        .err_digit  (err_digit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_value;
    logic [3:0]  m_valid, m_mask;
    logic        m_frame, m_err;
    logic [1:0]  m_err_digit;
    int          m_last, m_run;
    logic [10:0] m_s1, m_s2;

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [23:0] dut_bus();
        return {value, digit_valid, frame_pulse, err_pulse, err_digit};
    endfunction

    function automatic logic [23:0] model_bus();
        return {m_value, m_valid, m_frame, m_err, m_err_digit};
    endfunction

    task automatic model_reset();
        m_value = '0; m_valid = '0; m_mask = '0;
        m_frame = 1'b0; m_err = 1'b0; m_err_digit = '0;
        m_last = -1; m_run = 0;
        m_s1 = '1; m_s2 = '1;
    endtask

    // One clock edge of the model: a capture happens on the edge where a value has
    // been presented for S+1 consecutive edges.
    task automatic model_edge(input logic [3:0] an, input logic [6:0] sg);
        int eff, an_e, sg_e, zeros, k, hex;
`ifdef SEG_SYNC_EN
        eff  = int'(m_s2);
        m_s2 = m_s1;
        m_s1 = {an, sg};
`else
        eff = int'({an, sg});
`endif
        if (eff == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_last = eff;
            m_run  = 1;
        end
        m_frame = 1'b0;
        m_err   = 1'b0;
        if (m_run == S + 1) begin
            an_e  = (eff >> 7) & 15;
            sg_e  = eff & 127;
            zeros = 0;
            k     = 0;
            for (int b = 0; b < 4; b++) begin
                if (((an_e >> b) & 1) == 0) begin
                    zeros++;
                    k = b;
                end
            end
            if (zeros > 1) begin
                m_err = 1'b1;
                m_err_digit = 2'd0;
            end else if (zeros == 1) begin
                hex = -1;
                for (int h = 0; h < 16; h++) if (int'(pat[h]) == sg_e) hex = h;
                if (hex < 0) begin
                    m_valid[k]  = 1'b0;
                    m_err       = 1'b1;
                    m_err_digit = 2'(k);
                end else begin
                    m_value[4*k +: 4] = 4'(hex);
                    m_valid[k] = 1'b1;
                    m_mask[k]  = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_frame = 1'b1;
                        m_mask  = '0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] sg);
        @(negedge clk);
        anode_in = an;
        seg_in   = sg;
        @(posedge clk);
        model_edge(an, sg);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        anode_in = 4'hF;
        seg_in   = 7'h7F;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #3;
        total++;
        if (dut_bus() !== 24'h0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", dut_bus(), 24'h0);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (dut_bus() !== 24'h0) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=%h", dut_bus(), 24'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_digit();
        int cap_at, errs;
        do_reset();
        cap_at = -1;
        errs   = 0;
        for (int i = 1; i <= 10; i++) begin
            step(4'b1110, 7'b0110000);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL single cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
            if (cap_at < 0 && digit_valid === 4'b0001) cap_at = i;
            if (err_pulse === 1'b1) errs++;
        end
        total++;
        if (cap_at != int'(S) + 1 + SYNC_LAT) begin
            bad++;
            $display("FAIL single_latency got=%0d exp=%0d", cap_at, int'(S) + 1 + SYNC_LAT);
        end
        total++;
        if (value[3:0] !== 4'h3 || digit_valid !== 4'b0001 || errs != 0) begin
            bad++;
            $display("FAIL single_final got=%h/%b/%0d exp=3/0001/0", value[3:0], digit_valid, errs);
        end
    endtask

    task automatic test_scan();
        logic [6:0] sp [4];
        int frames, frame_digit;
        sp[0] = 7'b1111001; sp[1] = 7'b0100100; sp[2] = 7'b0001000; sp[3] = 7'b0001110;
        do_reset();
        frames = 0;
        frame_digit = -1;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 8; i++) begin
                step(~(4'b0001 << d), sp[d]);
                total++;
                if (dut_bus() !== model_bus()) begin
                    bad++;
                    $display("FAIL scan d=%0d cyc=%0d got=%h exp=%h", d, i, dut_bus(), model_bus());
                end
                if (frame_pulse === 1'b1) begin
                    frames++;
                    frame_digit = d;
                end
            end
        end
        total++;
        if (value !== 16'hFA21 || digit_valid !== 4'hF || frames != 1 || frame_digit != 3) begin
            bad++;
            $display("FAIL scan_final got=%h/%b/%0d/%0d exp=fa21/1111/1/3",
                     value, digit_valid, frames, frame_digit);
        end
    endtask

    task automatic test_bad_seg();
        int errs;
        logic [1:0] last_ed;
        errs = 0;
        last_ed = 2'd3;
        for (int i = 0; i < 8; i++) begin
            step(4'b1101, 7'b1111111);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL bad_seg cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
            if (err_pulse === 1'b1) begin
                errs++;
                last_ed = err_digit;
            end
        end
        total++;
        if (errs != 1 || last_ed !== 2'd1 || digit_valid !== 4'b1101 || value !== 16'hFA21) begin
            bad++;
            $display("FAIL bad_seg_final got=%0d/%0d/%b/%h exp=1/1/1101/fa21",
                     errs, last_ed, digit_valid, value);
        end
    endtask

    task automatic test_bad_anode();
        int errs, late_events;
        errs = 0;
        late_events = 0;
        for (int i = 0; i < 8; i++) begin
            step(4'b1100, 7'b1000000);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL bad_anode cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
            if (err_pulse === 1'b1) errs++;
        end
        total++;
        if (errs != 1 || err_digit !== 2'd0) begin
            bad++;
            $display("FAIL bad_anode_err got=%0d/%0d exp=1/0", errs, err_digit);
        end
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 7'b1000000);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL blank cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
            if (err_pulse !== 1'b0 || frame_pulse !== 1'b0) late_events++;
        end
        total++;
        if (late_events != 0 || value !== 16'hFA21 || digit_valid !== 4'b1101) begin
            bad++;
            $display("FAIL blank_final got=%0d/%h/%b exp=0/fa21/1101", late_events, value, digit_valid);
        end
    endtask

    task automatic test_toggle_and_reset();
        int events;
        events = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0111, ((i / 2) % 2 == 0) ? 7'b1000000 : 7'b1111001);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL toggle cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
            if (err_pulse !== 1'b0 || frame_pulse !== 1'b0) events++;
        end
        total++;
        if (events != 0 || value !== 16'hFA21 || digit_valid !== 4'b1101) begin
            bad++;
            $display("FAIL toggle_final got=%0d/%h/%b exp=0/fa21/1101", events, value, digit_valid);
        end
        step(4'b0111, 7'b0011001);
        step(4'b0111, 7'b0011001);
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (dut_bus() !== 24'h0) begin
            bad++;
            $display("FAIL mid_dwell_reset got=%h exp=%h", dut_bus(), 24'h0);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0111, 7'b0011001);
            total++;
            if (dut_bus() !== model_bus()) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, dut_bus(), model_bus());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] anl [8];
        logic [3:0] an;
        logic [6:0] sg;
        int dwell, cyc;
        anl[0] = 4'b1110; anl[1] = 4'b1101; anl[2] = 4'b1011; anl[3] = 4'b0111;
        anl[4] = 4'b1111; anl[5] = 4'b1100; anl[6] = 4'b0000; anl[7] = 4'b1010;
        do_reset();
        cyc = 0;
        while (cyc < 600) begin
            an = ($urandom_range(0, 9) < 7) ? anl[$urandom_range(0, 3)] : anl[$urandom_range(4, 7)];
            sg = ($urandom_range(0, 3) != 0) ? pat[$urandom_range(0, 15)] : 7'($urandom);
            dwell = $urandom_range(1, 9);
            for (int i = 0; i < dwell; i++) begin
                step(an, sg);
                cyc++;
                total++;
                if (dut_bus() !== model_bus()) begin
                    bad++;
                    $display("FAIL random cyc=%0d an=%b sg=%b got=%h exp=%h",
                             cyc, an, sg, dut_bus(), model_bus());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_scan();
        test_bad_seg();
        test_bad_anode();
        test_toggle_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
